// File: rtl/fetch_redirect_unit_pkg.sv
// fetch_redirect_unit_pkg
//   Shared definitions for the fetch front end: the sequencer state
//   encoding and the default 6502 reset-vector address, which other
//   front-end blocks reuse.
package fetch_redirect_unit_pkg;

  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'hFFFC;

  typedef enum logic [2:0] {
    ST_VEC_LO = 3'd0,
    ST_VEC_HI = 3'd1,
    ST_REQ    = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DRAIN  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit
//   Front-end PC sequencer. Boots from the reset vector, fetches bytes one
//   at a time and hands each byte, tagged with its PC, to the decoder.
//   A resolved target from the terminate pipeline restarts fetch at that
//   address and pulses flush.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   term_addr/valid/ready    redirect request from the terminate pipeline
//   mem_addr/req/ack/data    single-outstanding byte read port
//   fetch_byte/pc/valid/ready byte output to the decoder
//   flush                    one-cycle pulse per accepted redirect
//
// state    | meaning
// VEC_LO   | reading reset-vector low byte
// VEC_HI   | reading reset-vector high byte
// REQ      | read of pc outstanding
// HOLD     | fetched byte presented, waiting for the decoder
// DRAIN    | stale read outstanding after a redirect; its data is dropped
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] term_addr,
  input  logic        term_valid,
  output logic        term_ready,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  fetch_byte,
  output logic [15:0] fetch_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic        flush
);

  fetch_state_e state;
  logic [15:0]  pc;
  logic [7:0]   vec_lo;
  logic         ack;
  logic         redirect;

  // The first cycle out of reset has mem_req low; an ack then is not ours.
  assign ack      = mem_ack & mem_req;
  assign redirect = term_valid & term_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_VEC_LO;
      pc          <= 16'h0000;
      vec_lo      <= 8'h00;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      fetch_byte  <= 8'h00;
      fetch_pc    <= 16'h0000;
      flush       <= 1'b0;
      term_ready  <= 1'b0;
    end else begin
      flush <= redirect;
      if (redirect) begin
        pc <= term_addr;
      end

      case (state)
        ST_VEC_LO: begin
          mem_req <= 1'b1;
          if (ack) begin
            vec_lo   <= mem_data;
            mem_addr <= RESET_VECTOR + 16'd1;
            state    <= ST_VEC_HI;
          end
        end

        ST_VEC_HI: begin
          if (ack) begin
            pc         <= {mem_data, vec_lo};
            mem_addr   <= {mem_data, vec_lo};
            term_ready <= 1'b1;
            state      <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (redirect) begin
            fetch_valid <= 1'b0;
            if (ack) begin
              // Read completed in the accept cycle: drop it and start the
              // new request right away.
              mem_addr <= term_addr;
              state    <= ST_REQ;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (ack) begin
            fetch_byte  <= mem_data;
            fetch_pc    <= pc;
            fetch_valid <= 1'b1;
            pc          <= pc + 16'd1;
            mem_req     <= 1'b0;
            state       <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (redirect) begin
            fetch_valid <= 1'b0;
            mem_req     <= 1'b1;
            mem_addr    <= term_addr;
            state       <= ST_REQ;
          end else if (fetch_ready) begin
            fetch_valid <= 1'b0;
            mem_req     <= 1'b1;
            mem_addr    <= pc;
            state       <= ST_REQ;
          end
        end

        ST_DRAIN: begin
          // mem_req/mem_addr stay frozen until the stale read completes.
          if (ack) begin
            mem_addr <= redirect ? term_addr : pc;
            state    <= ST_REQ;
          end
        end

        default: begin
          state       <= ST_VEC_LO;
          mem_req     <= 1'b0;
          mem_addr    <= RESET_VECTOR;
          fetch_valid <= 1'b0;
          term_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit
//   Directed bench for fetch_redirect_unit: boot, backpressure, redirects in
//   REQ/HOLD/DRAIN, back-to-back redirects, PC wrap and reset mid-drain.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_fetch_redirect_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] term_addr;
  logic        term_valid;
  logic        term_ready;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  fetch_byte;
  logic [15:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        flush;

  fetch_redirect_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .term_addr   (term_addr),
    .term_valid  (term_valid),
    .term_ready  (term_ready),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .fetch_byte  (fetch_byte),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [15:0] req_q[$];
  logic [23:0] byte_q[$];
  int          ack_delay;
  int          wcnt;
  int          flush_cnt;
  int          n_cmp;
  int          n_fail;

  // One clock: log handshakes of the current cycle, advance, then let the
  // memory model decide this cycle's ack.
  task automatic step();
    if (mem_ack && mem_req) req_q.push_back(mem_addr);
    if (fetch_valid && fetch_ready) byte_q.push_back({fetch_pc, fetch_byte});
    @(posedge clk);
    #1;
    if (flush) flush_cnt++;
    if (!rst_n || !mem_req) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= ack_delay) begin
      mem_ack  = 1'b1;
      mem_data = mem[mem_addr];
      wcnt     = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 16'hFFFC) begin n_fail++; $display("FAIL reset_mem_addr: got %h want FFFC", mem_addr); end
    n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid); end
    n_cmp++; if (fetch_byte !== 8'h00) begin n_fail++; $display("FAIL reset_fetch_byte: got %h want 00", fetch_byte); end
    n_cmp++; if (fetch_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_fetch_pc: got %h want 0000", fetch_pc); end
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
    n_cmp++; if (term_ready !== 1'b0) begin n_fail++; $display("FAIL reset_term_ready: got %b want 0", term_ready); end
  endtask

  task automatic test_boot();
    int i;
    ack_delay   = 0;
    fetch_ready = 1'b1;
    rst_n       = 1'b1;
    step();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFC) begin n_fail++; $display("FAIL boot_first_req: got req=%b addr=%h want req=1 addr=FFFC", mem_req, mem_addr); end
    for (i = 0; i < 30 && byte_q.size() < 2; i++) begin
      if (req_q.size() < 2) begin
        n_cmp++; if (term_ready !== 1'b0) begin n_fail++; $display("FAIL boot_term_ready_early: got %b want 0 (cycle %0d)", term_ready, i); end
      end
      step();
    end
    n_cmp++; if (byte_q.size() != 2) begin n_fail++; $display("FAIL boot_timeout: got %0d bytes want 2", byte_q.size()); end
    n_cmp++; if (term_ready !== 1'b1) begin n_fail++; $display("FAIL boot_term_ready: got %b want 1", term_ready); end
    n_cmp++; if (req_q.size() < 4 || req_q[0] !== 16'hFFFC || req_q[1] !== 16'hFFFD || req_q[2] !== 16'h1234 || req_q[3] !== 16'h1235) begin
      n_fail++; $display("FAIL boot_req_seq: got %0d reqs want FFFC FFFD 1234 1235", req_q.size());
    end
    n_cmp++; if (byte_q.size() < 2 || byte_q[0] !== 24'h1234A9 || byte_q[1] !== 24'h123505) begin
      n_fail++; $display("FAIL boot_bytes: got %0d bytes want (1234,A9) (1235,05)", byte_q.size());
    end
    fetch_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int i;
    for (i = 0; i < 5 && !fetch_valid; i++) step();
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 16'h1236 || fetch_byte !== 8'hEA) begin
      n_fail++; $display("FAIL bp_first: got v=%b pc=%h b=%h want v=1 pc=1236 b=EA", fetch_valid, fetch_pc, fetch_byte);
    end
    for (i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (fetch_valid !== 1'b1 || fetch_byte !== 8'hEA || fetch_pc !== 16'h1236 || mem_req !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold: got v=%b b=%h pc=%h req=%b want v=1 b=EA pc=1236 req=0", fetch_valid, fetch_byte, fetch_pc, mem_req);
      end
    end
    ack_delay   = 3;
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h1237 || fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got req=%b addr=%h v=%b want req=1 addr=1237 v=0", mem_req, mem_addr, fetch_valid);
    end
  endtask

  task automatic test_redirect_pending();
    int i;
    flush_cnt  = 0;
    term_addr  = 16'h0200;
    term_valid = 1'b1;
    step();
    term_valid = 1'b0;
    n_cmp++; if (flush !== 1'b1 || mem_addr !== 16'h1237 || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rp_accept: got flush=%b addr=%h req=%b want flush=1 addr=1237 req=1", flush, mem_addr, mem_req);
    end
    for (i = 0; i < 10 && mem_addr !== 16'h0200; i++) begin
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h1237 || fetch_valid !== 1'b0) begin
        n_fail++; $display("FAIL rp_drain_hold: got req=%b addr=%h v=%b want req=1 addr=1237 v=0", mem_req, mem_addr, fetch_valid);
      end
      step();
    end
    n_cmp++; if (mem_addr !== 16'h0200 || mem_req !== 1'b1 || fetch_valid !== 1'b0) begin
      n_fail++; $display("FAIL rp_new_req: got addr=%h req=%b v=%b want addr=0200 req=1 v=0", mem_addr, mem_req, fetch_valid);
    end
    ack_delay = 0;
    for (i = 0; i < 10 && !fetch_valid; i++) step();
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 16'h0200 || fetch_byte !== 8'h11) begin
      n_fail++; $display("FAIL rp_byte: got v=%b pc=%h b=%h want v=1 pc=0200 b=11", fetch_valid, fetch_pc, fetch_byte);
    end
    n_cmp++; if (flush_cnt != 1) begin n_fail++; $display("FAIL rp_flush_count: got %0d want 1", flush_cnt); end
  endtask

  task automatic test_redirect_hold();
    flush_cnt   = 0;
    fetch_ready = 1'b1;
    term_addr   = 16'h0300;
    term_valid  = 1'b1;
    step();
    term_valid = 1'b0;
    n_cmp++; if (flush !== 1'b1 || fetch_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0300) begin
      n_fail++; $display("FAIL rh_accept: got flush=%b v=%b req=%b addr=%h want 1 0 1 0300", flush, fetch_valid, mem_req, mem_addr);
    end
    n_cmp++; if (byte_q.size() == 0 || byte_q[$] !== 24'h020011) begin
      n_fail++; $display("FAIL rh_old_byte: got %0d bytes want last (0200,11)", byte_q.size());
    end
    step();
    n_cmp++; if (flush !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== 16'h0300 || fetch_byte !== 8'h33) begin
      n_fail++; $display("FAIL rh_byte: got flush=%b v=%b pc=%h b=%h want 0 1 0300 33", flush, fetch_valid, fetch_pc, fetch_byte);
    end
  endtask

  task automatic test_back_to_back();
    int i;
    ack_delay = 4;
    step();
    fetch_ready = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0301) begin
      n_fail++; $display("FAIL bb_req: got req=%b addr=%h want 1 0301", mem_req, mem_addr);
    end
    flush_cnt  = 0;
    term_addr  = 16'h0300;
    term_valid = 1'b1;
    step();
    n_cmp++; if (flush !== 1'b1 || mem_addr !== 16'h0301) begin
      n_fail++; $display("FAIL bb_first: got flush=%b addr=%h want 1 0301", flush, mem_addr);
    end
    term_addr = 16'h0400;
    step();
    term_valid = 1'b0;
    n_cmp++; if (flush !== 1'b1 || mem_addr !== 16'h0301 || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL bb_second: got flush=%b addr=%h req=%b want 1 0301 1", flush, mem_addr, mem_req);
    end
    for (i = 0; i < 20 && !fetch_valid; i++) step();
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 16'h0400 || fetch_byte !== 8'h44) begin
      n_fail++; $display("FAIL bb_byte: got v=%b pc=%h b=%h want 1 0400 44", fetch_valid, fetch_pc, fetch_byte);
    end
    n_cmp++; if (flush_cnt != 2) begin n_fail++; $display("FAIL bb_flush_count: got %0d want 2", flush_cnt); end
    n_cmp++; if (req_q.size() < 2 || req_q[$] !== 16'h0400 || req_q[$-1] !== 16'h0301) begin
      n_fail++; $display("FAIL bb_req_seq: got last=%h want 0301 then 0400", req_q[$]);
    end
  endtask

  task automatic test_wrap_and_reset();
    int i;
    ack_delay  = 0;
    term_addr  = 16'hFFFF;
    term_valid = 1'b1;
    step();
    term_valid = 1'b0;
    n_cmp++; if (mem_addr !== 16'hFFFF || flush !== 1'b1) begin
      n_fail++; $display("FAIL wr_redirect: got addr=%h flush=%b want FFFF 1", mem_addr, flush);
    end
    step();
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 16'hFFFF || fetch_byte !== 8'h77) begin
      n_fail++; $display("FAIL wr_byte: got v=%b pc=%h b=%h want 1 FFFF 77", fetch_valid, fetch_pc, fetch_byte);
    end
    ack_delay   = 5;
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL wr_next: got req=%b addr=%h want 1 0000", mem_req, mem_addr);
    end
    term_addr  = 16'h0500;
    term_valid = 1'b1;
    step();
    term_valid = 1'b0;
    n_cmp++; if (flush !== 1'b1 || mem_addr !== 16'h0000 || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL wr_drain: got flush=%b addr=%h req=%b want 1 0000 1", flush, mem_addr, mem_req);
    end
    rst_n = 1'b0;
    step();
    n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 16'hFFFC || fetch_valid !== 1'b0 || fetch_byte !== 8'h00 ||
                 fetch_pc !== 16'h0000 || flush !== 1'b0 || term_ready !== 1'b0) begin
      n_fail++; $display("FAIL wr_reset: got req=%b addr=%h v=%b b=%h pc=%h flush=%b tr=%b want reset values",
                         mem_req, mem_addr, fetch_valid, fetch_byte, fetch_pc, flush, term_ready);
    end
    rst_n     = 1'b1;
    ack_delay = 0;
    step();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFC) begin
      n_fail++; $display("FAIL wr_reboot_req: got req=%b addr=%h want 1 FFFC", mem_req, mem_addr);
    end
    for (i = 0; i < 20 && !fetch_valid; i++) step();
    n_cmp++; if (fetch_valid !== 1'b1 || fetch_pc !== 16'h1234 || fetch_byte !== 8'hA9) begin
      n_fail++; $display("FAIL wr_reboot_byte: got v=%b pc=%h b=%h want 1 1234 A9", fetch_valid, fetch_pc, fetch_byte);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;
    mem[16'h1234] = 8'hA9;
    mem[16'h1235] = 8'h05;
    mem[16'h1236] = 8'hEA;
    mem[16'h0200] = 8'h11;
    mem[16'h0300] = 8'h33;
    mem[16'h0400] = 8'h44;
    mem[16'hFFFF] = 8'h77;
    mem[16'h0000] = 8'h88;

    rst_n       = 1'b0;
    term_addr   = 16'h0000;
    term_valid  = 1'b0;
    mem_ack     = 1'b0;
    mem_data    = 8'h00;
    fetch_ready = 1'b0;
    ack_delay   = 0;
    wcnt        = 0;
    flush_cnt   = 0;
    n_cmp       = 0;
    n_fail      = 0;

    test_reset();
    test_boot();
    test_backpressure();
    test_redirect_pending();
    test_redirect_hold();
    test_back_to_back();
    test_wrap_and_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Front-end PC sequencer and the consumer of the terminate pipeline's `result_addr`/`result_valid` output. It boots from the 6502 reset vector and fetches instruction bytes sequentially from memory. It hands each byte, tagged with its PC, to the decoder. When the terminate pipeline reports a resolved target, it restarts fetch at that address and signals a flush.

## Interface
Parameters:
- `RESET_VECTOR`, 16'hFFFC, address of the reset-vector low byte; the high byte is at `RESET_VECTOR+1`.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `term_addr`  in  16  redirect target from the terminate pipeline (its `result_addr`).
- `term_valid`  in  1  redirect request (its `result_valid`).
- `term_ready`  out  1  redirect can be accepted this cycle.
- `mem_addr`  out  16  fetch address.
- `mem_req`  out  1  read request; held with a stable `mem_addr` until `mem_ack`.
- `mem_ack`  in  1  read complete; `mem_data` valid in the same cycle.
- `mem_data`  in  8  read data.
- `fetch_byte`  out  8  fetched byte.
- `fetch_pc`  out  16  address of `fetch_byte`.
- `fetch_valid`  out  1  byte available.
- `fetch_ready`  in  1  decoder accepts the byte.
- `flush`  out  1  one-cycle pulse; the decoder discards all partially decoded state.

## Operation
- States: `VEC_LO`, `VEC_HI`, `REQ`, `HOLD`, `DRAIN`.
- `VEC_LO`:
  - `mem_req`=1, `mem_addr`=`RESET_VECTOR`.
  - On ack: latch the low byte, go to `VEC_HI`.
- `VEC_HI`:
  - `mem_addr`=`RESET_VECTOR+1`.
  - On ack: pc={data, low byte}, go to `REQ`.
- `REQ`:
  - `mem_req`=1, `mem_addr`=pc.
  - On ack: `fetch_byte`=data, `fetch_pc`=pc, `fetch_valid`=1, pc=pc+1, go to `HOLD`.
- `HOLD`:
  - `fetch_valid`=1, `mem_req`=0.
  - On `fetch_valid && fetch_ready`: go to `REQ`.
- `DRAIN`:
  - Keeps `mem_req`=1 with the stale address.
  - On ack: discard data, go to `REQ` at the redirected pc.
- `term_ready`=0 in `VEC_LO`/`VEC_HI`, 1 in every other state.
- Redirect accepted (`term_valid && term_ready`), next state per current state:
  - From `REQ` without ack: `DRAIN`.
  - From `REQ` with ack in the same cycle: data discarded, go to `REQ`.
  - From `HOLD`: `REQ`; `fetch_valid` drops.
  - From `DRAIN`: stay in `DRAIN`.
  - In all cases pc=`term_addr`.
- Redirect dominates a fetch ack and a consumer handshake in the same cycle. A byte handshaken in the accept cycle is older than the redirect and is the decoder's responsibility to discard on `flush`.
- Back-to-back redirects: the last accepted `term_addr` wins. `flush` pulses once per accepted redirect.
- PC arithmetic: 16-bit, wraps FFFF→0000. `RESET_VECTOR+1` also wraps.
- Exactly one memory request outstanding at any time. No prefetch beyond one byte.

## Timing
- Reset values (all outputs registered):
  - `mem_req`=0, `mem_addr`=`RESET_VECTOR`.
  - `fetch_valid`=0, `fetch_byte`=0, `fetch_pc`=0.
  - `flush`=0, `term_ready`=0.
  - State=`VEC_LO`.
- First cycle after `rst_n` rises: `mem_req`=1, `mem_addr`=`RESET_VECTOR`.
- Reset asserted mid-operation: all state returns to reset values on that edge. Outstanding ack data is ignored. Memory must abandon the request when `mem_req` drops under reset.
- Fetch latency: `mem_ack` at edge N gives `fetch_valid`=1 in cycle N+1. Consumer accept at N+1 gives `mem_req` for pc+1 in cycle N+2.
- Redirect accepted at edge N gives `flush`=1, `fetch_valid`=0, and the new state in cycle N+1. `mem_addr`=`term_addr` no earlier than N+1 (`REQ` path) or the cycle after the drain ack.
- `mem_req` and `mem_addr` must not change while a request is unacknowledged, including across a redirect.

## Structure
- Shared package holds:
  - state encoding constants;
  - the `RESET_VECTOR` default (16'hFFFC), reused by other front-end blocks.
- Single module, no sub-modules. The output byte register is a plain one-entry holding register inside `HOLD`.

## Test plan
- Boot: memory holds FFFC=34, FFFD=12, 1234=A9, 1235=05.
  - Expect requests FFFC, FFFD, 1234, 1235.
  - Expect bytes (1234,A9), (1235,05).
  - Expect `term_ready`=0 until the vector completes.
- Backpressure: `fetch_ready`=0 for 5 cycles.
  - `fetch_valid` and `fetch_byte` stay stable.
  - No new `mem_req` until accepted.
- Redirect during a pending request (`mem_ack` delayed 3 cycles), `term_addr`=0200.
  - `flush` pulses once.
  - Old address held until ack; that data is not presented.
  - Next request is 0200.
- Redirect in `HOLD` with `fetch_ready`=1 in the same cycle.
  - `flush`=1 next cycle, `fetch_valid`=0, next request at `term_addr`.
- Two redirects in consecutive cycles (0300 then 0400) while draining: two `flush` pulses, first fetched PC is 0400.
- Wrap: pc=FFFF. Fetch FFFF, then request 0000. Assert reset mid-`DRAIN`: the next cycle shows reset values, then a request for FFFC.
